// File: rtl/nn_pkg.sv
// Shared constants and state encoding for the fully-connected node interface.
package nn_pkg;

    localparam int DATA_W = 32;
    localparam int NUM_IN = 5;

    typedef enum logic [1:0] {
        FILL,
        HOLD,
        OUT
    } state_t;

endpackage

// File: rtl/node_frame_feeder.sv
// Collects five serial activations into a parallel frame for one layer node,
// waits out the node pipeline, then returns the node output as one result word.
module node_frame_feeder
    import nn_pkg::*;
#(
    parameter int LATENCY     = 3,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [DATA_W-1:0]      A0x,
    output logic [DATA_W-1:0]      A1x,
    output logic [DATA_W-1:0]      A2x,
    output logic [DATA_W-1:0]      A3x,
    output logic [DATA_W-1:0]      A4x,
    input  logic [DATA_W-1:0]      node_result,
    output logic [DATA_W-1:0]      res_data,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic                   busy,
    output logic [FRAME_CNT_W-1:0] frame_cnt
);

    // The wait counter must still hold one bit when LATENCY is zero.
    localparam int                CNT_W    = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0]  LAT_C    = CNT_W'(LATENCY);
    localparam logic [2:0]        LAST_IDX = 3'(NUM_IN - 1);

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [2:0]               r_idx;
    logic [CNT_W-1:0]         r_cnt;
    logic [DATA_W-1:0]        r_slot [NUM_IN];
    logic [DATA_W-1:0]        r_resData;
    logic                     r_resValid;
    logic [FRAME_CNT_W-1:0]   r_frameCnt;
    logic                     w_inReady;
    logic                     w_accept;
    logic                     w_lastWord;
    logic                     w_capture;
    logic                     w_resDone;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= FILL;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        w_inReady   = 1'b0;
        w_accept    = 1'b0;
        w_lastWord  = 1'b0;
        w_capture   = 1'b0;
        w_resDone   = 1'b0;
        case (r_state)
            FILL: begin
                w_inReady  = 1'b1;
                w_accept   = in_valid;
                w_lastWord = in_valid && (r_idx == LAST_IDX);
                if (w_lastWord) begin
                    w_stateNext = HOLD;
                end
            end
            HOLD: begin
                // Frame is held stable until the node pipeline has settled.
                if (r_cnt == LAT_C) begin
                    w_capture   = 1'b1;
                    w_stateNext = OUT;
                end
            end
            OUT: begin
                w_resDone = r_resValid && res_ready;
                if (w_resDone) begin
                    w_stateNext = FILL;
                end
            end
            default: begin
                w_stateNext = FILL;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx      <= '0;
            r_cnt      <= '0;
            r_resData  <= '0;
            r_resValid <= 1'b0;
            r_frameCnt <= '0;
            for (int i = 0; i < NUM_IN; i++) begin
                r_slot[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                r_slot[r_idx] <= in_data;
                r_idx         <= w_lastWord ? 3'd0 : r_idx + 3'd1;
            end
            if (w_lastWord) begin
                r_cnt <= '0;
            end else if (r_state == HOLD && !w_capture) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            // node_result is sampled exactly once per frame, on the capture edge.
            if (w_capture) begin
                r_resData  <= node_result;
                r_resValid <= 1'b1;
            end
            if (w_resDone) begin
                r_resValid <= 1'b0;
                r_frameCnt <= r_frameCnt + FRAME_CNT_W'(1);
            end
        end
    end

    assign in_ready  = w_inReady;
    assign A0x       = r_slot[0];
    assign A1x       = r_slot[1];
    assign A2x       = r_slot[2];
    assign A3x       = r_slot[3];
    assign A4x       = r_slot[4];
    assign res_data  = r_resData;
    assign res_valid = r_resValid;
    assign busy      = (r_state != FILL);
    assign frame_cnt = r_frameCnt;

endmodule

// File: tb/tb_node_frame_feeder.sv
// Scoreboard bench for node_frame_feeder with a behavioural 3-stage node model
// (input reg, sum reg, ReLU reg) or a free-running cycle counter on node_result.
module tb_node_frame_feeder;

    import nn_pkg::*;

    localparam int FCW = 2;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [31:0]    in_data = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [31:0]    A0x, A1x, A2x, A3x, A4x;
    logic [31:0]    node_result;
    logic [31:0]    res_data;
    logic           res_valid;
    logic           res_ready = 1'b1;
    logic           busy;
    logic [FCW-1:0] frame_cnt;

    int             assertCount = 0;
    int             failCount = 0;
    logic [31:0]    cyc = '0;
    logic           useCounter = 1'b1;
    logic [FCW-1:0] expFrames = '0;

    typedef struct {
        logic [31:0] data;
        logic [31:0] edgeNo;
    } expect_t;

    expect_t sbQueue[$];

    always #5 clk = ~clk;

    node_frame_feeder #(
        .LATENCY     (3),
        .FRAME_CNT_W (FCW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .A0x         (A0x),
        .A1x         (A1x),
        .A2x         (A2x),
        .A3x         (A3x),
        .A4x         (A4x),
        .node_result (node_result),
        .res_data    (res_data),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .busy        (busy),
        .frame_cnt   (frame_cnt)
    );

    always @(posedge clk) cyc <= cyc + 32'd1;

    // Behavioural node: weights 4223,-8192,-3942,675,-4355, bias -139.
    int          weights[5] = '{4223, -8192, -3942, 675, -4355};
    int          nIn[5];
    int          nSum;
    logic [31:0] nRelu;

    function automatic int dotProd();
        int acc = -139;
        for (int i = 0; i < 5; i++) acc += weights[i] * nIn[i];
        return acc;
    endfunction

    always @(posedge clk) begin
        nIn[0] <= A0x;
        nIn[1] <= A1x;
        nIn[2] <= A2x;
        nIn[3] <= A3x;
        nIn[4] <= A4x;
        nSum   <= dotProd();
        nRelu  <= (nSum < 0) ? 32'd0 : 32'(nSum);
    end

    assign node_result = useCounter ? cyc : nRelu;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
        end
    endtask

    // Monitor: each rising res_valid pops one expected result and its edge number.
    initial begin
        logic prevValid = 1'b0;
        expect_t e;
        forever begin
            @(negedge clk);
            if (!reset && res_valid && !prevValid) begin
                if (sbQueue.size() == 0) begin
                    checkOutput("unexpectedResult", 32'd1, 32'd0);
                end else begin
                    e = sbQueue.pop_front();
                    checkOutput("resData", res_data, e.data);
                    checkOutput("resValidEdge", cyc, e.edgeNo);
                end
            end
            prevValid = res_valid;
        end
    end

    // Drive one word and hold it until the feeder accepts it.
    task automatic applyStimulus(input logic [31:0] word);
        int n = 0;
        in_valid = 1'b1;
        in_data  = word;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) checkOutput("inReadyTimeout", 32'd0, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic sendFrame(input logic [31:0] a, b, c, d, e, input logic [31:0] expData, input bit counterMode);
        expect_t x;
        applyStimulus(a);
        applyStimulus(b);
        applyStimulus(c);
        applyStimulus(d);
        applyStimulus(e);
        in_valid = 1'b0;
        x.data   = counterMode ? cyc + 32'd3 : expData;
        x.edgeNo = cyc + 32'd4;
        sbQueue.push_back(x);
        checkOutput("A0x", A0x, a);
        checkOutput("A1x", A1x, b);
        checkOutput("A2x", A2x, c);
        checkOutput("A3x", A3x, d);
        checkOutput("A4x", A4x, e);
        checkOutput("busyInHold", {31'd0, busy}, 32'd1);
    endtask

    // Wait for the result, complete the handshake and check the frame counter.
    task automatic waitResult();
        int n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (!res_valid) checkOutput("resValidTimeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        expFrames++;
        checkOutput("frameCnt", {30'd0, frame_cnt}, {30'd0, expFrames});
        checkOutput("busyAfterResult", {31'd0, busy}, 32'd0);
        checkOutput("resValidCleared", {31'd0, res_valid}, 32'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("rstInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstResValid", {31'd0, res_valid}, 32'd0);
        checkOutput("rstResData", res_data, 32'd0);
        checkOutput("rstA0x", A0x, 32'd0);
        checkOutput("rstA4x", A4x, 32'd0);
        checkOutput("rstFrameCnt", {30'd0, frame_cnt}, 32'd0);

        // Counter-driven node_result: checks the capture edge precisely.
        sendFrame(32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd0, 1'b1);
        in_valid = 1'b1;
        in_data  = 32'd99;
        checkOutput("holdInReady0", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("holdInReady1", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1;
        checkOutput("holdInReady2", {31'd0, in_ready}, 32'd0);
        checkOutput("holdA0xStable", A0x, 32'd1);
        in_valid = 1'b0;
        waitResult();
        checkOutput("oldFrameKept", A0x, 32'd1);

        // Real node behaviour, including ReLU clamp.
        useCounter = 1'b0;
        sendFrame(32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd422161, 1'b0);
        waitResult();
        sendFrame(32'd0, 32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        waitResult();

        // Downstream stall: result held, upstream words refused.
        res_ready = 1'b0;
        sendFrame(32'd100, 32'd0, 32'd0, 32'd0, 32'd0, 32'd422161, 1'b0);
        begin
            int n = 0;
            while (!res_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
            end
        end
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'd77;
            @(posedge clk); #1;
            checkOutput("stallResValid", {31'd0, res_valid}, 32'd1);
            checkOutput("stallResData", res_data, 32'd422161);
            checkOutput("stallInReady", {31'd0, in_ready}, 32'd0);
            checkOutput("stallFrameCnt", {30'd0, frame_cnt}, {30'd0, expFrames});
        end
        in_valid = 1'b0;
        waitResult();

        // Reset in the middle of a frame discards the partial words.
        applyStimulus(32'd11);
        applyStimulus(32'd12);
        applyStimulus(32'd13);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        expFrames = '0;
        checkOutput("midRstA0x", A0x, 32'd0);
        checkOutput("midRstA2x", A2x, 32'd0);
        checkOutput("midRstInReady", {31'd0, in_ready}, 32'd1);
        checkOutput("midRstFrameCnt", {30'd0, frame_cnt}, 32'd0);

        // Four frames after reset: frame_cnt walks 1,2,3,0.
        sendFrame(32'd7, 32'd0, 32'd0, 32'd0, 32'd0, 32'd29422, 1'b0);
        waitResult();
        sendFrame(32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        waitResult();
        sendFrame(32'd0, 32'd0, 32'd0, 32'd1, 32'd0, 32'd536, 1'b0);
        waitResult();
        sendFrame(32'd200, 32'd0, 32'd0, 32'd0, 32'd2, 32'd835751, 1'b0);
        waitResult();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboardEmpty", 32'(sbQueue.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
